// File: rtl/fifo_pkg.sv
// Shared helpers for the async-FIFO pointer blocks: depth derivation, default
// almost-full threshold and Gray/binary conversion on a 32-bit carrier.
package fifo_pkg;

  function automatic int unsigned depth_of(input int unsigned width);
    return 32'd1 << width;
  endfunction

  function automatic int unsigned af_level_default(input int unsigned width);
    return depth_of(width) - 32'd2;
  endfunction

  // Callers zero-extend into 32 bits and size-cast the result back.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  logic [WIDTH-1:0] w_bin;

  always_comb begin
    w_bin            = '0;
    w_bin[WIDTH-1]   = i_gray[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      w_bin[i] = w_bin[i+1] ^ i_gray[i];
    end
  end

  assign o_bin = w_bin;

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer of an async FIFO: binary/Gray write pointer, registered
// full, almost-full and level flags, and a sticky overflow error.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned AF_LEVEL = af_level_default(WIDTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           winc,
  input  logic [WIDTH:0] wq2_rptr,
  output logic           wen,
  output logic [WIDTH-1:0] waddr,
  output logic [WIDTH:0] wptr,
  output logic           wfull,
  output logic           walmost_full,
  output logic [WIDTH:0] wlevel,
  output logic           woverflow
);

  localparam int unsigned PtrW  = WIDTH + 1;
  localparam int unsigned DEPTH = depth_of(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $error("wptr_full_ctrl: WIDTH must be at least 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("wptr_full_ctrl: AF_LEVEL must not exceed DEPTH");
  end

  logic [WIDTH:0] r_wbin;
  logic [WIDTH:0] r_wptr;
  logic           r_wfull;
  logic           r_walmost_full;
  logic [WIDTH:0] r_wlevel;
  logic           r_woverflow;

  logic           w_wen;
  logic [WIDTH:0] w_wbin_next;
  logic [WIDTH:0] w_wgray_next;
  logic [WIDTH:0] w_rbin;
  logic [WIDTH:0] w_full_match;
  logic [WIDTH:0] w_level_next;
  logic           w_full_next;
  logic           w_af_next;

  gray2bin #(
    .WIDTH (PtrW)
  ) u_rptr_gray2bin (
    .i_gray (wq2_rptr),
    .o_bin  (w_rbin)
  );

  // Full when the next write pointer sits exactly one lap ahead of the read pointer.
  assign w_full_match = {~wq2_rptr[WIDTH:WIDTH-1], wq2_rptr[WIDTH-2:0]};

  always_comb begin
    w_wen        = winc & ~r_wfull;
    w_wbin_next  = r_wbin + {{WIDTH{1'b0}}, w_wen};
    w_wgray_next = PtrW'(bin2gray(32'(w_wbin_next)));
    w_full_next  = (w_wgray_next == w_full_match);
    w_level_next = w_wbin_next - w_rbin;
    w_af_next    = (w_level_next >= PtrW'(AF_LEVEL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wlevel       <= '0;
      r_woverflow    <= 1'b0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_wptr         <= w_wgray_next;
      r_wfull        <= w_full_next;
      r_walmost_full <= w_af_next;
      r_wlevel       <= w_level_next;
      r_woverflow    <= r_woverflow | (winc & r_wfull);
    end
  end

  assign wen          = w_wen;
  assign waddr        = r_wbin[WIDTH-1:0];
  assign wptr         = r_wptr;
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wlevel       = r_wlevel;
  assign woverflow    = r_woverflow;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl (WIDTH=3, AF_LEVEL=6) with an occupancy model.
module tb_wptr_full_ctrl;

  localparam int W  = 3;
  localparam int NP = 16;  // pointer space 2^(W+1)
  localparam int AF = 6;

  logic         clk;
  logic         rst_n;
  logic         winc;
  logic [W:0]   wq2_rptr;
  logic         wen;
  logic [W-1:0] waddr;
  logic [W:0]   wptr;
  logic         wfull;
  logic         walmost_full;
  logic [W:0]   wlevel;
  logic         woverflow;

  int total = 0;
  int bad   = 0;

  wptr_full_ctrl #(
    .WIDTH    (W),
    .AF_LEVEL (AF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) % NP;
  endfunction

  // Decode by search: the binary value whose Gray code matches.
  function automatic int ungray(input int g);
    for (int b = 0; b < NP; b++) begin
      if (gray(b) == g) return b;
    end
    return 0;
  endfunction

  // Model: count accepted writes, derive occupancy from the read pointer.
  int m_wb, m_lvl;
  bit m_full, m_af, m_ov;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wb = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ov = 0;
    end else begin
      if (winc && m_full) m_ov = 1;
      if (winc && !m_full) m_wb = (m_wb + 1) % NP;
      m_lvl  = (m_wb - ungray(int'(wq2_rptr)) + NP) % NP;
      m_full = (m_lvl == (NP / 2));
      m_af   = (m_lvl >= AF);
    end
  end

  always @(negedge clk) begin
    chk("cyc_wen",    32'(wen),          32'(winc & ~m_full));
    chk("cyc_waddr",  32'(waddr),        32'(m_wb % (NP / 2)));
    chk("cyc_wptr",   32'(wptr),         32'(gray(m_wb)));
    chk("cyc_wfull",  32'(wfull),        32'(m_full));
    chk("cyc_af",     32'(walmost_full), 32'(m_af));
    chk("cyc_wlevel", 32'(wlevel),       32'(m_lvl));
    chk("cyc_ovf",    32'(woverflow),    32'(m_ov));
  end

  // Drive inputs (just after an edge), then advance past the next edge.
  task automatic cyc(input logic inc, input logic [W:0] rp);
    winc     = inc;
    wq2_rptr = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    winc  = 1'b0;
    wq2_rptr = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [W:0] fill_exp [8];
  logic [W:0] prev;
  bit         saw_wrap;
  int         wb;

  initial begin
    fill_exp = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    rst_n    = 1'b0;
    winc     = 1'b1;
    wq2_rptr = '0;
    #3;
    chk("rst_wen", 32'(wen), 32'd1);
    chk("rst_wptr", 32'(wptr), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    winc  = 1'b0;

    // Fill
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 4'h0);
      chk("fill_wptr", 32'(wptr), 32'(fill_exp[k]));
      if (k == 4) chk("fill_af_low", 32'(walmost_full), 32'd0);
      if (k == 5) begin
        chk("fill_af_rise", 32'(walmost_full), 32'd1);
        chk("fill_lvl6", 32'(wlevel), 32'd6);
      end
    end
    chk("fill_full", 32'(wfull), 32'd1);
    chk("fill_lvl8", 32'(wlevel), 32'd8);

    // Overflow
    winc = 1'b1;
    #1;
    chk("ovf_wen", 32'(wen), 32'd0);
    cyc(1'b1, 4'h0);
    chk("ovf_wptr", 32'(wptr), 32'hC);
    chk("ovf_set", 32'(woverflow), 32'd1);
    cyc(1'b0, 4'h0);
    chk("ovf_hold", 32'(woverflow), 32'd1);

    // Drain
    cyc(1'b0, 4'h1);
    chk("drain_full", 32'(wfull), 32'd0);
    chk("drain_lvl", 32'(wlevel), 32'd7);
    cyc(1'b1, 4'h1);
    chk("drain_refill", 32'(wfull), 32'd1);
    chk("drain_wptr", 32'(wptr), 32'hD);

    // Simultaneous write and read advance while full
    winc     = 1'b1;
    wq2_rptr = 4'h3;
    #1;
    chk("sim_wen", 32'(wen), 32'd0);
    @(posedge clk);
    #1;
    chk("sim_wptr_hold", 32'(wptr), 32'hD);
    chk("sim_full_clr", 32'(wfull), 32'd0);
    chk("sim_lvl", 32'(wlevel), 32'd7);
    cyc(1'b1, 4'h3);
    chk("sim_wptr_next", 32'(wptr), 32'hF);
    chk("sim_full", 32'(wfull), 32'd1);

    // Async reset with level 5
    cyc(1'b0, 4'h7);
    chk("ar_lvl5", 32'(wlevel), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_wptr", 32'(wptr), 32'd0);
    chk("ar_waddr", 32'(waddr), 32'd0);
    chk("ar_full", 32'(wfull), 32'd0);
    chk("ar_af", 32'(walmost_full), 32'd0);
    chk("ar_lvl", 32'(wlevel), 32'd0);
    chk("ar_ovf", 32'(woverflow), 32'd0);

    // Wrap: reader trails so the level settles at 2
    do_reset();
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h0);
    wb       = 2;
    saw_wrap = 1'b0;
    for (int i = 0; i < 16; i++) begin
      prev = wptr;
      cyc(1'b1, 4'(gray((wb + NP - 1) % NP)));
      wb = (wb + 1) % NP;
      chk("wrap_onebit", 32'($countones(prev ^ wptr)), 32'd1);
      if (prev == 4'h8 && wptr == 4'h0) saw_wrap = 1'b1;
    end
    chk("wrap_seen", 32'(saw_wrap), 32'd1);
    chk("wrap_lvl", 32'(wlevel), 32'd2);
    chk("wrap_wptr", 32'(wptr), 32'h3);
    chk("wrap_nofull", 32'(wfull), 32'd0);
    cyc(1'b0, 4'(gray(1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
